// File: rtl/sys_reset_seq.sv
// sys_reset_seq: sequenced reset controller.
// Synchronises an active-low reset request, holds every stage in reset for
// ASSERT_CYC cycles after the request goes away, then releases stage resets
// one at a time every STAGE_CYC cycles. oREADY rises STAGE_CYC cycles after
// the last stage release.
//
// Interface contract: there is no handshake. iRESET_N_REQ is a level that
// may change at any time. The outputs are plain registered levels, and they
// all change on the same clock edge as the state.
module sys_reset_seq #(
    parameter int STAGES     = 3,
    parameter int ASSERT_CYC = 16,
    parameter int STAGE_CYC  = 8,
    parameter int CNT_W      = 16
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iRESET_N_REQ,
    output logic [STAGES-1:0] oRESET_N,
    output logic              oREADY,
    output logic [1:0]        oSTATE
);

    localparam int K_W = $clog2(STAGES + 1);

    localparam logic [CNT_W-1:0]  ASSERT_LAST = CNT_W'(ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST  = CNT_W'(STAGE_CYC - 1);
    localparam logic [K_W-1:0]    K_LAST      = K_W'(STAGES);
    localparam logic [STAGES-1:0] STAGE_ONE   = STAGES'(1);

    // The debug encoding is exposed directly on oSTATE.
    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [STAGES-1:0] rst_n_q, rst_n_d;
    logic              ready_q, ready_d;
    logic              s1_q, s2_q;
    logic              req_active;

    // Two-flop request synchroniser. Both flops reset to the inactive level (1).
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= iRESET_N_REQ;
            s2_q <= s1_q;
        end
    end

    assign req_active = ~s2_q;

    // State, counters and all outputs are registered together.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            k_q     <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic. An active request overrides every state and restarts
    // the whole sequence, including stages that were already released.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        if (req_active) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            k_d     = '0;
            rst_n_d = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    if (cnt_q == ASSERT_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        k_d     = K_W'(1);
                        rst_n_d = STAGE_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d = '0;
                        if (k_q < K_LAST) begin
                            // Released bits are kept, so the pattern stays a prefix.
                            rst_n_d = rst_n_q | (STAGE_ONE << k_q);
                            k_d     = k_q + K_W'(1);
                        end else begin
                            state_d = ST_DONE;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    rst_n_d = '1;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    k_d     = '0;
                    rst_n_d = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign oRESET_N = rst_n_q;
    assign oREADY   = ready_q;
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Testbench for sys_reset_seq with STAGES=3, ASSERT_CYC=4, STAGE_CYC=2.
// Edge numbers count posedges of iCLK. A value "at edge N" is the value seen
// on the falling edge that follows posedge N. The driver pushes packed
// expectations tagged with an edge number. The monitor pops and compares each
// expectation when its edge arrives, and it also checks on every cycle that
// oRESET_N is a release prefix with at most one bit rising per edge.
module tb_sys_reset_seq;

    localparam int STAGES = 3;
    localparam int ACYC   = 4;
    localparam int SCYC   = 2;
    localparam int W      = 24;   // {edge[17:0], state[1:0], ready, rst_n[2:0]}

    logic              iCLK;
    logic              iRESET;
    logic              iRESET_N_REQ;
    logic [STAGES-1:0] oRESET_N;
    logic              oREADY;
    logic [1:0]        oSTATE;

    sys_reset_seq #(
        .STAGES    (STAGES),
        .ASSERT_CYC(ACYC),
        .STAGE_CYC (SCYC),
        .CNT_W     (16)
    ) dut (
        .iCLK        (iCLK),
        .iRESET      (iRESET),
        .iRESET_N_REQ(iRESET_N_REQ),
        .oRESET_N    (oRESET_N),
        .oREADY      (oREADY),
        .oSTATE      (oSTATE)
    );

    // ---------------- clock / reset ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int edge_cnt = 0;
    always @(posedge iCLK) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests_run = 0;
    int           fail_cnt  = 0;
    logic [2:0]   prev_rst  = 3'b000;

    task automatic push(input int cyc, input logic [2:0] rst, input logic rdy,
                        input logic [1:0] st, input string nm);
        logic [17:0] c;
        c = cyc[17:0];
        exp_q.push_back({c, st, rdy, rst});
        name_q.push_back(nm);
    endtask

    // Standard release sequence with stage 0 released at edge base.
    task automatic expect_seq(input int base, input string nm);
        push(base - 1,        3'b000, 1'b0, 2'd0, {nm, "_pre"});
        push(base,            3'b001, 1'b0, 2'd1, {nm, "_s0"});
        push(base + 1,        3'b001, 1'b0, 2'd1, {nm, "_s0h"});
        push(base + SCYC,     3'b011, 1'b0, 2'd1, {nm, "_s1"});
        push(base + 2 * SCYC, 3'b111, 1'b0, 2'd1, {nm, "_s2"});
        push(base + 5,        3'b111, 1'b0, 2'd1, {nm, "_nrdy"});
        push(base + 3 * SCYC, 3'b111, 1'b1, 2'd2, {nm, "_rdy"});
    endtask

    // Monitor: compares every expectation that is due and checks the invariants.
    always @(negedge iCLK) begin
        logic [W-1:0] e;
        string        nm;
        logic [2:0]   rise;
        while (exp_q.size() > 0 && int'(exp_q[0][23:6]) <= edge_cnt) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (int'(e[23:6]) != edge_cnt || {oSTATE, oREADY, oRESET_N} !== e[5:0]) begin
                fail_cnt++;
                $display("FAIL %s @edge %0d: got rst_n=%b ready=%b state=%0d, want rst_n=%b ready=%b state=%0d (due edge %0d)",
                         nm, edge_cnt, oRESET_N, oREADY, oSTATE, e[2:0], e[3], e[5:4], int'(e[23:6]));
            end
        end
        if (edge_cnt >= 1) begin
            rise = oRESET_N & ~prev_rst;
            tests_run++;
            if (!(oRESET_N inside {3'b000, 3'b001, 3'b011, 3'b111}) || $countones(rise) > 1) begin
                fail_cnt++;
                $display("FAIL prefix @edge %0d: got rst_n=%b after %b, want a prefix pattern with at most one rising bit",
                         edge_cnt, oRESET_N, prev_rst);
            end
            prev_rst = oRESET_N;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge iCLK);
    endtask

    task automatic wait_drain(input string nm);
        int budget;
        budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge iCLK);
            #2;
            budget--;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            fail_cnt++;
            $display("FAIL drain_%s: got %0d pending expectations, want 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        iRESET       = 1'b1;
        iRESET_N_REQ = 1'b1;

        // 1: hard reset for edges 1..3 (R=3), then free-running release.
        push(1, 3'b000, 1'b0, 2'd0, "rst_hold");
        push(3, 3'b000, 1'b0, 2'd0, "rst_last");
        expect_seq(3 + ACYC, "por");
        wait_edge(3);
        iRESET = 1'b0;
        wait_drain("por");

        // 2: one-cycle request sampled at edge E, starting from DONE.
        e = edge_cnt + 1;
        push(e + 1, 3'b111, 1'b1, 2'd2, "req1_lat");
        push(e + 2, 3'b000, 1'b0, 2'd0, "req1_drop");
        expect_seq(e + 6, "req1");
        iRESET_N_REQ = 1'b0;
        wait_edge(e);
        iRESET_N_REQ = 1'b1;
        wait_drain("req1");

        // 3: request held low for 20 samples, last low sample at L = E+19.
        e = edge_cnt + 1;
        push(e + 1,  3'b111, 1'b1, 2'd2, "hold_lat");
        push(e + 2,  3'b000, 1'b0, 2'd0, "hold_drop");
        push(e + 10, 3'b000, 1'b0, 2'd0, "hold_mid");
        push(e + 19, 3'b000, 1'b0, 2'd0, "hold_last");
        push(e + 21, 3'b000, 1'b0, 2'd0, "hold_l2");
        expect_seq(e + 19 + 6, "hold");
        iRESET_N_REQ = 1'b0;
        wait_edge(e + 19);
        iRESET_N_REQ = 1'b1;
        wait_drain("hold");

        // 4: the second request becomes active on the edge that would give 011,
        // so the pattern goes 001 -> 000 without ever showing 011.
        e = edge_cnt + 1;
        push(e + 2, 3'b000, 1'b0, 2'd0, "mid_drop1");
        push(e + 5, 3'b000, 1'b0, 2'd0, "mid_pre");
        push(e + 6, 3'b001, 1'b0, 2'd1, "mid_s0");
        push(e + 7, 3'b001, 1'b0, 2'd1, "mid_s0h");
        push(e + 8, 3'b000, 1'b0, 2'd0, "mid_drop2");
        expect_seq(e + 6 + 6, "mid_rerun");
        iRESET_N_REQ = 1'b0;
        wait_edge(e);
        iRESET_N_REQ = 1'b1;
        wait_edge(e + 5);
        iRESET_N_REQ = 1'b0;
        wait_edge(e + 6);
        iRESET_N_REQ = 1'b1;
        wait_drain("mid");

        // 5: hard reset while the pattern is 011, with iRESET high only at edge E+9.
        e = edge_cnt + 1;
        push(e + 2, 3'b000, 1'b0, 2'd0, "hr_drop");
        push(e + 6, 3'b001, 1'b0, 2'd1, "hr_s0");
        push(e + 8, 3'b011, 1'b0, 2'd1, "hr_s1");
        push(e + 9, 3'b000, 1'b0, 2'd0, "hr_clear");
        expect_seq(e + 9 + ACYC, "hr");
        iRESET_N_REQ = 1'b0;
        wait_edge(e);
        iRESET_N_REQ = 1'b1;
        wait_edge(e + 8);
        iRESET = 1'b1;
        wait_edge(e + 9);
        iRESET = 1'b0;
        wait_drain("hr");

        // 6: request toggling every cycle for 10 cycles, low at even offsets.
        e = edge_cnt + 1;
        push(e + 1,  3'b111, 1'b1, 2'd2, "tog_lat");
        push(e + 2,  3'b000, 1'b0, 2'd0, "tog_drop");
        push(e + 5,  3'b000, 1'b0, 2'd0, "tog_mid");
        push(e + 9,  3'b000, 1'b0, 2'd0, "tog_end");
        expect_seq(e + 8 + 6, "tog");
        for (int i = 0; i < 10; i++) begin
            iRESET_N_REQ = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_edge(e + i);
        end
        iRESET_N_REQ = 1'b1;
        wait_drain("tog");

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
